lsu_ctrl: RTL and testbench
===========================

// Module: lsu_ctrl
// PURPOSE
//  Load/store unit directly upstream of DMEM. Takes core LB/LH/LW/LBU/LHU/SB/SH/SW requests, and drives the
//  word-wide DMEM port (MemRead/MemWrite/word address). Sub-word stores become read-modify-write sequences;
//  loads are sign/zero extended. Misaligned accesses and illegal funct3 values are flagged.
//  Core stalls on lsu_busy and advances on lsu_done.
// PARAMETERS
//  ADDR_W       32  core/DMEM address width
//  CHECK_ALIGN  1   1: misaligned access -> lsu_err, no DMEM access; 0: low addr bits forced to natural alignment
// PORTS
//  clk          in   1       system clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  lsu_req      in   1       request; sampled only in IDLE
//  lsu_we       in   1       1 store, 0 load
//  lsu_funct3   in   3       RV32I funct3 of the load/store
//  lsu_addr     in   ADDR_W  byte address
//  lsu_wdata    in   32      store data (rs2)
//  lsu_rdata    out  32      extended load result, valid while lsu_done=1
//  lsu_busy     out  1       access in progress; core holds PC/regs
//  lsu_done     out  1       1-cycle completion pulse
//  lsu_err      out  1       with lsu_done: misaligned or illegal funct3
//  MemRead      out  1       to DMEM
//  MemWrite     out  1       to DMEM
//  mem_addr     out  ADDR_W  to DMEM addr, always word aligned ([1:0]=0)
//  mem_wdata    out  32      to DMEM WriteData
//  mem_rdata    in   32      from DMEM ReadData; combinational, valid in the same cycle as MemRead
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs and internal regs 0. Reset mid-op aborts the op and
//   no further DMEM write is issued.
//  Request latch: in IDLE with lsu_req=1, latch we/funct3/addr/wdata; later changes to the inputs are ignored.
//  Legal funct3 values:
//   loads  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
//   stores 000 SB, 001 SH, 010 SW
//  Error: illegal funct3, or (CHECK_ALIGN=1 and) half with addr[0]!=0, or word with addr[1:0]!=0.
//  FSM: IDLE, RD, WR, RMW_RD, RMW_WR, RESP.
//   IDLE   -> RESP (error) | RD (load) | WR (SW) | RMW_RD (SB/SH)
//   RD     : MemRead=1; capture mem_rdata at the clock edge; -> RESP
//   WR     : MemWrite=1, mem_wdata=latched wdata; -> RESP
//   RMW_RD : MemRead=1; capture the old word; -> RMW_WR
//   RMW_WR : MemWrite=1; mem_wdata = old word with the byte/half lane replaced by wdata[7:0]/[15:0]; -> RESP
//   RESP   : lsu_done=1; lsu_err valid; -> IDLE unconditionally; lsu_req ignored in this cycle
//  lsu_busy=1 in RD, WR, RMW_RD, RMW_WR; 0 in IDLE and RESP.
//  MemRead and MemWrite are never both 1. Both are 0 in IDLE and RESP.
//  mem_addr = {latched addr[ADDR_W-1:2], 2'b00} while accessing, else 0.
//  Latency, counted from accept cycle T (IDLE, lsu_req=1):
//   loads and SW: lsu_done at T+2
//   SB/SH: lsu_done at T+3
//   error: lsu_done with lsu_err=1 at T+1
//  Load extraction: lane select by addr[1:0] (LB/LBU) or addr[1] (LH/LHU).
//   LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
//  lsu_rdata=0 outside RESP, for stores, and on error. lsu_err=0 except in an error RESP.
//  Store lanes:
//   byte k = bits [8k+7:8k]
//   half 0 = [15:0], half 1 = [31:16]
//  Error path: no DMEM access; memory is unchanged.
//  Back-to-back: the next request is accepted in the IDLE cycle after RESP (minimum 1 idle cycle).
// TESTING
//  1 SW addr 0x08 data 0xABCD1234, then LW 0x08
//    -> exactly one MemWrite cycle, mem_addr=0x08
//    -> LW: lsu_done at T+2 with lsu_rdata=0xABCD1234
//  2 SB addr 0x0A wdata 0x00000055 over 0xABCD1234
//    -> MemRead then MemWrite with mem_wdata=0xAB551234; lsu_done at T+3
//  3 LB 0x0B -> 0xFFFFFFAB; LBU 0x0B -> 0x000000AB; LH 0x0A -> 0xFFFFAB55; LHU 0x0A -> 0x0000AB55
//  4 LW 0x06, SH 0x09, and funct3=011
//    -> lsu_err=1 with lsu_done at T+1; MemRead=MemWrite=0 throughout; word 0x08 unchanged
//  5 SH 0x08 wdata 0x1234; pull rst_n low during RMW_RD
//    -> all outputs 0 immediately, MemWrite never asserted
//    -> after release: IDLE, lsu_busy=0
//  6 lsu_req held high across 3 back-to-back LWs
//    -> each accepted only in IDLE; done pulses 3 cycles apart; busy never overlaps done

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit driving a word-wide DMEM port, with RMW sub-word stores,
// sign/zero-extended loads and misalignment/illegal-funct3 detection.
module lsu_ctrl #(
    parameter int ADDR_W      = 32,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_funct3,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [31:0]       lsu_wdata,
    output logic [31:0]       lsu_rdata,
    output logic              lsu_busy,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD     = 3'd1;
    localparam logic [2:0] WR     = 3'd2;
    localparam logic [2:0] RMW_RD = 3'd3;
    localparam logic [2:0] RMW_WR = 3'd4;
    localparam logic [2:0] RESP   = 3'd5;

    logic [2:0]        state, nextState;
    logic              reqWe, reqErr;
    logic [2:0]        reqFunct3;
    logic [ADDR_W-1:0] reqAddr;
    logic [31:0]       reqWdata, memWord;
    logic              legal, misaligned, newErr, accessing;
    logic [1:0]        size, laneAddr;
    logic [4:0]        shift;
    logic [31:0]       mask, merged, shifted, loadVal;

    always_comb begin
        legal      = lsu_we ? (lsu_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (lsu_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misaligned = CHECK_ALIGN && ((lsu_funct3[1:0] == 2'b01 && lsu_addr[0])
                                  || (lsu_funct3[1:0] == 2'b10 && lsu_addr[1:0] != 2'b00));
        newErr     = !legal || misaligned;
        nextState  = state == IDLE   ? (!lsu_req ? IDLE : newErr ? RESP : !lsu_we ? RD
                                        : lsu_funct3 == 3'b010 ? WR : RMW_RD) :
                     state == RMW_RD ? RMW_WR :
                     (state == RD || state == WR || state == RMW_WR) ? RESP : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            reqWe     <= 1'b0;
            reqErr    <= 1'b0;
            reqFunct3 <= '0;
            reqAddr   <= '0;
            reqWdata  <= '0;
            memWord   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && lsu_req) begin
                reqWe     <= lsu_we;
                reqErr    <= newErr;
                reqFunct3 <= lsu_funct3;
                reqAddr   <= lsu_addr;
                reqWdata  <= lsu_wdata;
            end
            if (state == RD || state == RMW_RD)
                memWord <= mem_rdata;
        end
    end

    // Lane offset is forced to natural alignment; with alignment checking on,
    // any access that reaches DMEM is already aligned so this changes nothing.
    always_comb begin
        size      = reqFunct3[1:0];
        laneAddr  = size == 2'b10 ? 2'b00 : size == 2'b01 ? {reqAddr[1], 1'b0} : reqAddr[1:0];
        shift     = {laneAddr, 3'b000};
        mask      = (size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << shift;
        merged    = (memWord & ~mask) | ((reqWdata << shift) & mask);
        shifted   = memWord >> shift;
        loadVal   = size == 2'b00 ? {{24{~reqFunct3[2] & shifted[7]}}, shifted[7:0]} :
                    size == 2'b01 ? {{16{~reqFunct3[2] & shifted[15]}}, shifted[15:0]} : memWord;
        accessing = state == RD || state == WR || state == RMW_RD || state == RMW_WR;
        lsu_busy  = accessing;
        lsu_done  = state == RESP;
        lsu_err   = state == RESP && reqErr;
        lsu_rdata = (state == RESP && !reqWe && !reqErr) ? loadVal : 32'h0;
        MemRead   = state == RD || state == RMW_RD;
        MemWrite  = state == WR || state == RMW_WR;
        mem_addr  = accessing ? {reqAddr[ADDR_W-1:2], 2'b00} : '0;
        mem_wdata = state == WR ? reqWdata : state == RMW_WR ? merged : 32'h0;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed scoreboard bench for lsu_ctrl against a behavioural DMEM.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0, lsu_we = 1'b0;
    logic [2:0]  lsu_funct3 = '0;
    logic [31:0] lsu_addr = '0, lsu_wdata = '0;
    logic [31:0] lsu_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        lsu_busy, lsu_done, lsu_err, MemRead, MemWrite;

    lsu_ctrl #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy),
        .lsu_done(lsu_done), .lsu_err(lsu_err), .MemRead(MemRead), .MemWrite(MemWrite),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:63];
    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (MemWrite) mem[mem_addr[7:2]] <= mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic err; logic [31:0] rdata; int cyc; } DoneExp;
    typedef struct { logic [31:0] addr; logic [31:0] data; } WriteExp;
    DoneExp  doneQ[$];
    WriteExp writeQ[$];
    int compared = 0, mismatched = 0;
    logic noAccess = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT completes or writes DMEM.
    always @(negedge clk) begin
        DoneExp  d;
        WriteExp w;
        check("excl", {62'b0, MemRead && MemWrite, lsu_busy && lsu_done}, 64'h0);
        if (noAccess) check("noaccess", {63'b0, MemRead || MemWrite}, 64'h0);
        if (lsu_done) begin
            if (doneQ.size() == 0) check("unexpected_done", 64'h1, 64'h0);
            else begin
                d = doneQ.pop_front();
                check("rdata", {32'h0, lsu_rdata}, {32'h0, d.rdata});
                check("err", {63'h0, lsu_err}, {63'h0, d.err});
                check("done_cycle", 64'(cyc), 64'(d.cyc));
            end
        end
        if (MemWrite) begin
            if (writeQ.size() == 0) check("unexpected_write", 64'h1, 64'h0);
            else begin
                w = writeQ.pop_front();
                check("wr_addr", {32'h0, mem_addr}, {32'h0, w.addr});
                check("wr_data", {32'h0, mem_wdata}, {32'h0, w.data});
            end
        end
    end

    task automatic expWrite(input logic [31:0] a, input logic [31:0] d);
        WriteExp w;
        w.addr = a;
        w.data = d;
        writeQ.push_back(w);
    endtask

    // Called at an IDLE-cycle negedge; returns at the negedge of the following IDLE cycle.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         input logic expErr, input logic [31:0] expRd, input int lat);
        DoneExp e;
        bit seen = 0;
        e.err = expErr;
        e.rdata = expRd;
        e.cyc = cyc + lat;
        doneQ.push_back(e);
        noAccess = expErr;
        lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = wd;
        @(posedge clk);
        #1;
        lsu_req = 1'b0; lsu_we = ~we; lsu_funct3 = 3'b111; lsu_addr = 32'hFFFF_FFFF; lsu_wdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = lsu_done;
        end
        if (!seen) check("done_timeout", 64'h0, 64'h1);
        @(negedge clk);
        noAccess = 1'b0;
    endtask

    initial begin
        int dones;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {lsu_busy, lsu_done, lsu_err, MemRead, MemWrite, 27'h0, mem_addr},
              64'h0);
        check("reset_data", {lsu_rdata, mem_wdata}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        expWrite(32'h08, 32'hABCD1234);
        issue(1'b1, 3'b010, 32'h08, 32'hABCD1234, 1'b0, 32'h0, 2);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hABCD1234, 2);

        expWrite(32'h08, 32'hAB551234);
        issue(1'b1, 3'b000, 32'h0A, 32'h00000055, 1'b0, 32'h0, 3);

        issue(1'b0, 3'b000, 32'h0B, 32'h0, 1'b0, 32'hFFFFFFAB, 2);
        issue(1'b0, 3'b100, 32'h0B, 32'h0, 1'b0, 32'h000000AB, 2);
        issue(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 32'hFFFFAB55, 2);
        issue(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0000AB55, 2);
        issue(1'b0, 3'b000, 32'h08, 32'h0, 1'b0, 32'h00000034, 2);
        issue(1'b0, 3'b001, 32'h08, 32'h0, 1'b0, 32'h00001234, 2);

        issue(1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, 3'b001, 32'h09, 32'h0000BEEF, 1'b1, 32'h0, 1);
        issue(1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b1, 3'b100, 32'h08, 32'h0, 1'b1, 32'h0, 1);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hAB551234, 2);

        expWrite(32'h08, 32'hBEEF1234);
        issue(1'b1, 3'b001, 32'h0A, 32'hFFFFBEEF, 1'b0, 32'h0, 3);
        issue(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 32'h0000BEEF, 2);
        issue(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 32'hFFFFBEEF, 2);

        // Reset during the read half of an SH read-modify-write.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_funct3 = 3'b001; lsu_addr = 32'h08; lsu_wdata = 32'h1234;
        @(posedge clk);
        #1;
        lsu_req = 1'b0;
        check("rmw_rd_read", {31'h0, MemRead, mem_addr}, {31'h0, 1'b1, 32'h08});
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {lsu_busy, lsu_done, lsu_err, MemRead, MemWrite, 27'h0, mem_addr},
              64'h0);
        check("abort_data", {lsu_rdata, mem_wdata}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {62'h0, lsu_busy, lsu_done}, 64'h0);
        issue(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 32'hBEEF1234, 2);

        // lsu_req held high: one LW accepted per IDLE cycle, three cycles apart.
        for (int k = 0; k < 3; k++) begin
            DoneExp e;
            e.err = 1'b0;
            e.rdata = 32'hBEEF1234;
            e.cyc = cyc + 2 + 3 * k;
            doneQ.push_back(e);
        end
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_addr = 32'h08;
        dones = 0;
        for (int i = 0; i < 20 && dones < 3; i++) begin
            @(negedge clk);
            if (lsu_done) dones++;
        end
        lsu_req = 1'b0;
        check("held_req_dones", 64'(dones), 64'd3);

        repeat (4) @(negedge clk);
        check("done_queue_empty", 64'(doneQ.size()), 64'h0);
        check("write_queue_empty", 64'(writeQ.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
